// File: rtl/parse_sampler.sv
// Kyber uniform rejection sampler: walks squeezed SHAKE128 blocks three bytes at a
// time and emits the 12-bit candidates below Q over a valid/ready coefficient stream.
module parse_sampler #(
    parameter int unsigned R = 1344,
    parameter int unsigned Q = 3329,
    parameter int unsigned N = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [R-1:0]  blk_in,
    input  logic          blk_valid,
    output logic          blk_ready,
    output logic [11:0]   coef_out,
    output logic [7:0]    coef_idx,
    output logic          coef_valid,
    input  logic          coef_ready,
    output logic          done
);

    localparam int unsigned NT = R / 24;
    localparam int unsigned KW = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [KW-1:0] KLast   = KW'(NT - 1);
    localparam logic [8:0]    CntLast = 9'(N - 1);
    localparam logic [11:0]   QBound  = 12'(Q);

    typedef enum logic [2:0] {
        StIdle,
        StWaitBlk,
        StEmitD1,
        StEmitD2,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [R-1:0]    blk_q, blk_d;
    logic [KW-1:0]   k_q, k_d;
    logic [8:0]      count_q, count_d;

    logic [23:0]     triple;
    logic [11:0]     d1, d2, cand;
    logic            cand_ok;
    logic            emitting;
    logic            hs;

    always_comb begin
        triple = '0;
        for (int i = 0; i < NT; i++) begin
            if (k_q == KW'(i)) begin
                triple = blk_q[24*i +: 24];
            end
        end
    end

    // d1 = b0 + 256*(b1 mod 16), d2 = (b1 div 16) + 16*b2: both are plain slices.
    assign d1 = triple[11:0];
    assign d2 = triple[23:12];

    assign emitting = (state_q == StEmitD1) || (state_q == StEmitD2);
    assign cand     = (state_q == StEmitD2) ? d2 : d1;
    assign cand_ok  = cand < QBound;

    assign coef_valid = emitting && cand_ok;
    assign hs         = coef_valid && coef_ready;
    assign coef_out   = coef_valid ? cand : 12'd0;
    assign coef_idx   = coef_valid ? count_q[7:0] : 8'd0;
    assign blk_ready  = (state_q == StWaitBlk);
    assign done       = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        k_d     = k_q;
        count_d = count_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWaitBlk;
                    count_d = '0;
                    k_d     = '0;
                end
            end

            StWaitBlk: begin
                if (blk_valid) begin
                    blk_d   = blk_in;
                    k_d     = '0;
                    state_d = StEmitD1;
                end
            end

            StEmitD1: begin
                if (hs) begin
                    count_d = count_q + 9'd1;
                    state_d = (count_q == CntLast) ? StDone : StEmitD2;
                end else if (!cand_ok) begin
                    state_d = StEmitD2;
                end
            end

            StEmitD2: begin
                if (hs && (count_q == CntLast)) begin
                    count_d = count_q + 9'd1;
                    state_d = StDone;
                end else if (hs || !cand_ok) begin
                    count_d = count_q + {8'd0, hs};
                    if (k_q == KLast) begin
                        state_d = StWaitBlk;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StEmitD1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            blk_q   <= '0;
            k_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            k_q     <= k_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_parse_sampler.sv
// Directed bench for parse_sampler: table of single-triple vectors plus stall,
// reset and full-polynomial sequences.
module tb_parse_sampler;

    localparam int R = 1344;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [R-1:0]  blk_in;
    logic          blk_valid;
    logic          blk_ready;
    logic [11:0]   coef_out;
    logic [7:0]    coef_idx;
    logic          coef_valid;
    logic          coef_ready;
    logic          done;

    int passed = 0;
    int total  = 0;

    parse_sampler #(.R(R), .Q(3329), .N(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .blk_in     (blk_in),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .coef_out   (coef_out),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic        v1;
        logic [11:0] d1;
        logic        v2;
        logic [11:0] d2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_rdy"}, int'(blk_ready), 0);
        check({name, "_val"}, int'(coef_valid), 0);
        check({name, "_out"}, int'(coef_out), 0);
        check({name, "_idx"}, int'(coef_idx), 0);
        check({name, "_done"}, int'(done), 0);
    endtask

    // Runs one whole polynomial from reset with zero blocks; if special, block 0
    // starts with a rejected d1 so that index 255 lands on a d1 with a valid d2.
    task automatic run_fill(input bit special);
        int          exp_idx;
        int          nblk;
        int          cyc;
        bit          last;
        logic [R-1:0] sblk;
        sblk = '0;
        sblk[7:0]  = 8'h01;
        sblk[15:8] = 8'h0D;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        blk_valid  = 1'b1;
        coef_ready = 1'b1;
        exp_idx = 0;
        nblk    = 0;
        cyc     = 0;
        last    = 1'b0;
        while (!done && cyc < 3000) begin
            if (blk_ready) begin
                blk_in = (special && nblk == 0) ? sblk : '0;
                nblk++;
            end
            if (coef_valid) begin
                check("fill_val", int'(coef_out), 0);
                check("fill_idx", int'(coef_idx), exp_idx & 255);
                last = (exp_idx == 255);
                exp_idx++;
            end
            tick();
            cyc++;
            if (last) begin
                check("fill_done_next", int'(done), 1);
                check("fill_no_d2", int'(coef_valid), 0);
                check("fill_rdy_low", int'(blk_ready), 0);
                last = 1'b0;
            end
        end
        blk_valid = 1'b0;
        check("fill_timeout", int'(cyc < 3000), 1);
        check("fill_count", exp_idx, 256);
        check("fill_blocks", nblk, 3);
        repeat (3) begin
            tick();
            check("hold_done", int'(done), 1);
            check("hold_rdy", int'(blk_ready), 0);
            check("hold_val", int'(coef_valid), 0);
        end
    endtask

    initial begin
        int exp_idx;
        int n;

        vecs[0] = '{b0: 8'h01, b1: 8'h23, b2: 8'h45, v1: 1, d1: 12'd769,  v2: 1, d2: 12'd1106};
        vecs[1] = '{b0: 8'h00, b1: 8'h0D, b2: 8'h00, v1: 1, d1: 12'd3328, v2: 1, d2: 12'd0};
        vecs[2] = '{b0: 8'h01, b1: 8'h0D, b2: 8'h00, v1: 0, d1: 12'd0,    v2: 1, d2: 12'd0};
        vecs[3] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, v1: 0, d1: 12'd0,    v2: 0, d2: 12'd0};
        vecs[4] = '{b0: 8'h00, b1: 8'h10, b2: 8'hD0, v1: 1, d1: 12'd0,    v2: 0, d2: 12'd0};
        vecs[5] = '{b0: 8'h00, b1: 8'h00, b2: 8'hD0, v1: 1, d1: 12'd0,    v2: 1, d2: 12'd3328};

        rst        = 1'b1;
        start      = 1'b0;
        blk_in     = '0;
        blk_valid  = 1'b0;
        coef_ready = 1'b1;
        tick();
        tick();
        check_quiet("reset");
        rst       = 1'b0;
        blk_valid = 1'b1;
        repeat (3) begin
            tick();
            check_quiet("idle");
        end
        blk_valid = 1'b0;

        // Table: triple 0 from the vector, the rest all 0xFF (always rejected).
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_idx = 0;
        for (int v = 0; v < 6; v++) begin
            check("tbl_rdy", int'(blk_ready), 1);
            blk_in = '1;
            blk_in[23:0] = {vecs[v].b2, vecs[v].b1, vecs[v].b0};
            blk_valid = 1'b1;
            tick();
            blk_valid = 1'b0;
            check("tbl_v1", int'(coef_valid), int'(vecs[v].v1));
            if (vecs[v].v1) begin
                check("tbl_d1", int'(coef_out), int'(vecs[v].d1));
                check("tbl_i1", int'(coef_idx), exp_idx);
                exp_idx++;
            end
            tick();
            check("tbl_v2", int'(coef_valid), int'(vecs[v].v2));
            if (vecs[v].v2) begin
                check("tbl_d2", int'(coef_out), int'(vecs[v].d2));
                check("tbl_i2", int'(coef_idx), exp_idx);
                exp_idx++;
            end
            tick();
            n = 0;
            while (!blk_ready && n < 200) begin
                if (coef_valid) check("tbl_spurious", 1, 0);
                tick();
                n++;
            end
            check("tbl_gap", n, 110);
        end

        // Stall: coef_ready low for 5 cycles while a coefficient is offered.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_rdy", int'(blk_ready), 1);
        blk_in = '1;
        blk_in[23:0] = 24'h452301;
        blk_valid  = 1'b1;
        coef_ready = 1'b0;
        tick();
        blk_valid = 1'b0;
        repeat (5) begin
            check("st_val", int'(coef_valid), 1);
            check("st_out", int'(coef_out), 769);
            check("st_idx", int'(coef_idx), 0);
            tick();
        end
        check("st_held", int'(coef_out), 769);
        coef_ready = 1'b1;
        tick();
        check("st_d2", int'(coef_out), 1106);
        check("st_d2_idx", int'(coef_idx), 1);
        tick();
        check("st_after", int'(coef_valid), 0);

        // Reset while in EMIT_D2 with count 100.
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        blk_in = '0;
        blk_in[7:0]  = 8'h01;
        blk_in[15:8] = 8'h0D;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        n = 0;
        while (!(coef_valid && coef_idx == 8'd100) && n < 300) begin
            tick();
            n++;
        end
        check("mr_reach", int'(n < 300), 1);
        check("mr_is_d2", int'(coef_out), 0);
        rst = 1'b1;
        tick();
        check_quiet("mr_reset");
        rst = 1'b0;
        blk_valid = 1'b1;
        repeat (2) begin
            tick();
            check_quiet("mr_idle");
        end
        start = 1'b1;
        blk_in = '0;
        tick();
        start = 1'b0;
        check("mr_rdy", int'(blk_ready), 1);
        tick();
        blk_valid = 1'b0;
        check("mr_val", int'(coef_valid), 1);
        check("mr_idx0", int'(coef_idx), 0);

        // Full polynomial, last index on d2 then on d1.
        run_fill(1'b0);
        run_fill(1'b1);

        // Restart from DONE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done", int'(done), 0);
        check("restart_rdy", int'(blk_ready), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
